data_memory_ctrl: RTL and testbench
===================================

DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, meaning data word width in bits; legal values are multiples of 8, from 8 to 64.
REQ-002 SHALL provide parameter ADDR_W, default 8, meaning word-address width; DEPTH = 2**ADDR_W words, with ADDR_W legal from 4 to 12.
REQ-003 SHALL provide parameter CLEAR_VAL, default 0, meaning the value written to every word during a clear sweep.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 clear  input  1  one-cycle request to start a clear sweep.
REQ-007 req  input  1  access request, qualified by ready.
REQ-008 we  input  1  1 = write, 0 = read, sampled with req.
REQ-009 addr  input  16  CPU word address; bits [ADDR_W-1:0] index the array.
REQ-010 wdata  input  DATA_W  write data.
REQ-011 be  input  DATA_W/8  byte enables for writes; bit i covers wdata[8i+7:8i].
REQ-012 ready  output  1  controller accepts req this cycle.
REQ-013 rvalid  output  1  rdata valid, one-cycle pulse.
REQ-014 rdata  output  DATA_W  registered read data.
REQ-015 err  output  1  one-cycle pulse: out-of-range access rejected.

Function
REQ-016 SHALL implement a state machine with states CLEAR and IDLE; ready = 1 only in IDLE.
REQ-017 SHALL treat an access as accepted when req & ready are both high at a rising edge.
REQ-018 Accepted write SHALL update only the bytes whose be bit is 1; be = 0 SHALL leave the word unchanged and still count as accepted.
REQ-019 Accepted read SHALL drive rdata with the array word and pulse rvalid exactly 1 cycle after acceptance; reads ignore be.
REQ-020 Back-to-back reads SHALL be accepted every cycle, with one rvalid per read, in order.
REQ-021 A read accepted the cycle after a write to the same address SHALL return the newly written bytes.
REQ-022 rdata SHALL hold its last value when rvalid = 0.
REQ-023 If addr[15:ADDR_W] != 0 on an accepted access, SHALL not modify the array, SHALL not pulse rvalid, and SHALL pulse err 1 cycle after acceptance.
REQ-024 clear asserted in IDLE SHALL move to CLEAR on the next edge; a req in that same cycle SHALL still be accepted, because ready was high.
REQ-025 CLEAR SHALL write CLEAR_VAL to one word per cycle, addresses 0 through DEPTH-1 in ascending order, using an internal ADDR_W-bit counter.
REQ-026 After writing word DEPTH-1, SHALL return to IDLE, so ready rises DEPTH cycles after entering CLEAR.
REQ-027 clear asserted while in CLEAR SHALL be ignored, and the sweep SHALL not restart.
REQ-028 req asserted while ready = 0 SHALL be ignored, with no side effects; the requester holds its request.

Reset
REQ-029 rst_n low SHALL immediately force state CLEAR, clear counter = 0, ready = 0, rvalid = 0, err = 0, and rdata = 0.
REQ-030 On rst_n release, SHALL run a full clear sweep, with ready rising DEPTH cycles after the first clk edge with rst_n high.
REQ-031 rst_n asserted mid-sweep or mid-access SHALL abort the operation; a pending rvalid or err SHALL not appear.

Verification
REQ-032 Reset then wait -> ready = 0 for 256 cycles (defaults), then ready = 1; a read of addr 0x00A5 returns 0x0000 with rvalid 1 cycle later.
REQ-033 Write 0x1234 to addr 0x0010 with be = 2'b11, then a write of 0xABCD with be = 2'b01, then a read -> rdata = 0x12CD.
REQ-034 Read addr 0x0100 (out of range) -> err pulses 1 cycle later, rvalid stays 0, and word 0x00 is unchanged.
REQ-035 Write 0x5555 to 0x0003, assert clear, then poll -> ready low for 256 cycles; a subsequent read of 0x0003 returns 0x0000.
REQ-036 Reads of addresses 1, 2, 3 on consecutive cycles -> three rvalid pulses on consecutive cycles carrying data in order.
REQ-037 Assert rst_n low at cycle 100 of the sweep -> outputs go to reset values asynchronously, and after release the sweep restarts at address 0.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// Single-port data memory controller with byte-enabled writes,
// registered reads and a self-clearing sweep after reset or on request.
module data_memory_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                req,
  input  logic                we,
  input  logic [15:0]         addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic                ready,
  output logic                rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned NB    = DATA_W / 8;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_IDLE  = 1'b1;

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept;
  logic              in_range;
  logic [ADDR_W-1:0] idx;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [NB-1:0]     wr_be;

  // Request qualification and address decode
  always_comb begin
    idx      = addr[ADDR_W-1:0];
    in_range = (addr[15:ADDR_W] == '0);
    ready    = (state_q == S_IDLE);
    accept   = req & ready;
  end

  // Sweep/idle sequencing; the counter sits at zero while idle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        cnt_d = '0;
        if (clear) begin
          state_d = S_CLEAR;
        end
      end
      default: begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Single write port shared by the sweep and CPU writes
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = idx;
    wr_data = wdata;
    wr_be   = be;
    if (state_q == S_CLEAR) begin
      wr_en   = 1'b1;
      wr_idx  = cnt_q;
      wr_data = CLEAR_VAL;
      wr_be   = '1;
    end else if (accept && we && in_range) begin
      wr_en = 1'b1;
    end
  end

  // Read response and range-error pulses
  always_comb begin
    rvalid_d = accept & ~we & in_range;
    err_d    = accept & ~in_range;
    rdata_d  = rdata_q;
    if (rvalid_d) begin
      rdata_d = mem_q[idx];
    end
  end

  // Control and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_CLEAR;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage array, byte-granular write
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (wr_be[i]) begin
          mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  assign rvalid = rvalid_q;
  assign err    = err_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl at default parameters.
// Expected values are hand-computed constants.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [1:0]  be;
  logic        ready;
  logic        rvalid;
  logic [15:0] rdata;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  data_memory_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .be     (be),
    .ready  (ready),
    .rvalid (rvalid),
    .rdata  (rdata),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [15:0] a,
                       input logic [15:0] d, input logic [1:0] b);
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    be    = b;
  endtask

  task automatic idle();
    req = 1'b0;
    we  = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!ready && n < 1000);
    check(tag, n, 256);
  endtask

  initial begin
    int n;
    int spur;
    logic [15:0] exp_d [3];
    exp_d[0] = 16'h1111;
    exp_d[1] = 16'h2222;
    exp_d[2] = 16'h3333;

    rst_n = 1'b0;
    clear = 1'b0;
    idle();
    addr  = '0;
    wdata = '0;
    be    = '0;
    #12;
    check("rst_ready", ready, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 0);

    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("boot_len");

    drive(0, 16'h00A5, 0, 0);
    cyc();
    idle();
    check("rd_a5_valid", rvalid, 1);
    check("rd_a5_data", rdata, 16'h0000);
    check("rd_a5_err", err, 0);
    cyc();
    check("rvalid_pulse", rvalid, 0);

    drive(1, 16'h0010, 16'h1234, 2'b11);
    cyc();
    drive(1, 16'h0010, 16'hABCD, 2'b01);
    cyc();
    drive(0, 16'h0010, 0, 0);
    cyc();
    idle();
    check("be_merge_valid", rvalid, 1);
    check("be_merge_data", rdata, 16'h12CD);
    cyc();
    check("hold_valid", rvalid, 0);
    check("hold_data", rdata, 16'h12CD);

    drive(1, 16'h0010, 16'hFFFF, 2'b00);
    cyc();
    drive(0, 16'h0010, 0, 0);
    cyc();
    idle();
    check("be0_keep", rdata, 16'h12CD);

    drive(1, 16'h0000, 16'h7777, 2'b11);
    cyc();
    drive(0, 16'h0100, 0, 0);
    cyc();
    idle();
    check("oor_rd_err", err, 1);
    check("oor_rd_rvalid", rvalid, 0);
    cyc();
    check("err_pulse", err, 0);
    drive(1, 16'h0100, 16'hBEEF, 2'b11);
    cyc();
    idle();
    check("oor_wr_err", err, 1);
    drive(0, 16'h0000, 0, 0);
    cyc();
    idle();
    check("word0_kept", rdata, 16'h7777);
    check("word0_err", err, 0);

    for (int i = 0; i < 3; i++) begin
      drive(1, 16'(i + 1), exp_d[i], 2'b11);
      cyc();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 16'(i + 1), 0, 0);
      cyc();
      check($sformatf("b2b_v%0d", i), rvalid, 1);
      check($sformatf("b2b_d%0d", i), rdata, exp_d[i]);
    end
    idle();
    cyc();
    check("b2b_end", rvalid, 0);

    drive(1, 16'h0003, 16'h5555, 2'b11);
    cyc();
    drive(0, 16'h0003, 0, 0);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    check("clr_same_valid", rvalid, 1);
    check("clr_same_data", rdata, 16'h5555);
    check("clr_ready", ready, 0);
    n = 0;
    spur = 0;
    do begin
      clear = (n == 50);
      cyc();
      n++;
      if (rvalid) spur++;
    end while (!ready && n < 1000);
    clear = 1'b0;
    check("clr_len", n, 256);
    check("clr_no_rvalid", spur, 0);
    cyc();
    idle();
    check("clr_rd_valid", rvalid, 1);
    check("clr_rd_data", rdata, 16'h0000);

    drive(1, 16'h0070, 16'h9999, 2'b11);
    cyc();
    drive(0, 16'h0070, 0, 0);
    cyc();
    idle();
    check("pre_rst_data", rdata, 16'h9999);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    repeat (100) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready", ready, 0);
    check("arst_rdata", rdata, 0);
    check("arst_rvalid", rvalid, 0);
    check("arst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("resweep_len");
    drive(0, 16'h0070, 0, 0);
    cyc();
    idle();
    check("resweep_valid", rvalid, 1);
    check("resweep_data", rdata, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
